// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// Index type is sized for the largest supported requester count.
// Pure definitions; no logic or timing.
package ram_arb_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int IDX_W     = $clog2(N_REQ_MAX);

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Next requester index after idx, wrapping n-1 back to 0.
  function automatic req_idx_t wrap_inc(req_idx_t idx, int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle of the RAM port arbiter.
// No latency of its own; pure wiring.
// Flow control is valid/ready per requester; responses are unthrottled pulses.
interface ram_port_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  // Requester side
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_we;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_rdata;

  // RAM side
  logic                        ram_cs;
  logic                        ram_we;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic [DATA_WIDTH-1:0]       ram_wdata;
  logic [DATA_WIDTH-1:0]       ram_rdata;

  // Arbiter view
  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_cs, ram_we, ram_addr, ram_wdata
  );

  // Requester/RAM environment view
  modport master (
    output req_valid, req_we, req_last, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_cs, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_picker.sv
// Round-robin winner selection: first set bit of valid_i at or after ptr_i, wrapping.
// Purely combinational, zero latency.
// No backpressure; any_o low when no candidate is valid.
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  req_idx_t         ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output req_idx_t         idx_o,
  output logic             any_o
);

  int j;

  // Scan candidates starting at the pointer; the first valid one wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!any_o && valid_i[j]) begin
        any_o       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = req_idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM among N_REQ requesters, round-robin with burst lock.
// Grant and RAM drive are combinational in cycle T; read data returns with rsp_valid in T+2.
// req_ready is one-hot to the winner only; everyone else holds valid until granted.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  state_t                  state_q;
  req_idx_t                ptr_q;
  req_idx_t                lock_q;

  logic [N_REQ-1:0]        lock_mask;
  logic [N_REQ-1:0]        elig;
  logic [N_REQ-1:0]        pick_oh;
  req_idx_t                pick_idx;
  logic                    pick_any;
  logic [N_REQ-1:0]        grant_oh;
  logic                    grant_any;

  logic                    g_we;
  logic                    g_last;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_wdata;

  logic [ADDR_WIDTH-1:0]   last_addr_q;
  logic                    rd_pend_q;
  req_idx_t                rd_idx_q;
  logic [N_REQ-1:0]        rsp_vld_d;
  logic [N_REQ-1:0]        rsp_vld_q;
  logic [DATA_WIDTH-1:0]   rsp_dat_q;

  // While a burst holds the lock, only the lock owner is a candidate.
  always_comb begin
    lock_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      lock_mask[i] = (lock_q == req_idx_t'(i));
    end
    elig = (state_q == BURST) ? (bus.req_valid & lock_mask) : bus.req_valid;
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .valid_i  (elig),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // No grant may leak out while reset is held, even with valid inputs.
  assign grant_oh      = rst ? '0 : pick_oh;
  assign grant_any     = pick_any & ~rst;
  assign bus.req_ready = grant_oh;

  // One-hot select of the winner's access fields.
  always_comb begin
    g_we    = 1'b0;
    g_last  = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        g_we    = bus.req_we[i];
        g_last  = bus.req_last[i];
        g_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // RAM drive: new access wins; otherwise keep cs high for a pending capture
  // by re-reading the previous address, which cannot disturb the data being captured.
  always_comb begin
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = last_addr_q;
    bus.ram_wdata = '0;
    if (grant_any) begin
      bus.ram_cs    = 1'b1;
      bus.ram_we    = g_we;
      bus.ram_addr  = g_addr;
      bus.ram_wdata = g_wdata;
    end else if (rd_pend_q) begin
      bus.ram_cs    = 1'b1;
    end
  end

  // Arbitration FSM: pointer advances past the finishing requester, lock held through a burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else if (grant_any) begin
      case (state_q)
        IDLE: begin
          if (g_last) begin
            ptr_q <= wrap_inc(pick_idx, N_REQ);
          end else begin
            state_q <= BURST;
            lock_q  <= pick_idx;
          end
        end
        BURST: begin
          if (g_last) begin
            state_q <= IDLE;
            ptr_q   <= wrap_inc(lock_q, N_REQ);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response one-hot for the read captured this cycle.
  always_comb begin
    rsp_vld_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_vld_d[i] = rd_pend_q && (rd_idx_q == req_idx_t'(i));
    end
  end

  // Read tag pipe: stage 1 marks the accepted read, stage 2 captures RAM data and pulses rsp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      last_addr_q <= '0;
      rsp_vld_q   <= '0;
      rsp_dat_q   <= '0;
    end else begin
      rd_pend_q <= grant_any & ~g_we;
      rd_idx_q  <= pick_idx;
      if (grant_any) begin
        last_addr_q <= g_addr;
      end
      rsp_vld_q <= rsp_vld_d;
      if (rd_pend_q) begin
        rsp_dat_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rsp_dat_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM plus a reference model of the arbitration rules.
// Directed scenarios followed by randomized traffic, checked every cycle.
// Inputs driven #1 after posedge, outputs sampled on negedge.
module tb_ram_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port RAM: registered read, data_out floats when not selected.
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_obuf;
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_dat;

  always @(posedge clk) begin
    if (pre_en) ram_mem[pre_addr] <= pre_dat;
    else if (bus.ram_cs) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_obuf <= ram_mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = bus.ram_cs ? ram_obuf : 'z;

  // Reference model state
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_g  = -1;
  int m_ptr, m_lock;
  bit m_locked, m_prev_rd;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_rdata;
  logic [DW-1:0] ref_mem [16];
  typedef struct { int due; int idx; logic [DW-1:0] data; } rsp_t;
  rsp_t rsp_q[$];

  // Snapshots of DUT outputs taken at the latest sample point
  logic [N-1:0]  obs_rdy, obs_rsp_vld;
  logic          obs_cs, obs_we;
  logic [DW-1:0] obs_rsp_dat;

  // Random traffic bookkeeping
  bit held [N];
  int left [N];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, bit v, bit w, bit l, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.req_valid[i]           = v;
    bus.req_we[i]              = w;
    bus.req_last[i]            = l;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_last  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic preload(logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_dat = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Winner under the arbitration rules: lock owner only during a burst,
  // otherwise first valid requester at/after the pointer.
  function automatic int model_winner();
    if (rst) return -1;
    if (m_locked) return bus.req_valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: check outputs on negedge, advance the model on posedge.
  task automatic tick();
    int g;
    logic [N-1:0]  exp_oh, exp_rsp;
    logic [DW-1:0] exp_dat;
    @(negedge clk);
    obs_rdy = bus.req_ready; obs_cs = bus.ram_cs; obs_we = bus.ram_we;
    obs_rsp_vld = bus.rsp_valid; obs_rsp_dat = bus.rsp_rdata;
    g = model_winner();
    exp_oh = '0;
    if (g >= 0) exp_oh[g] = 1'b1;
    chk("req_ready", obs_rdy, exp_oh);
    chk("ram_cs", obs_cs, (g >= 0) || m_prev_rd);
    if (g >= 0) begin
      chk("ram_we", obs_we, bus.req_we[g]);
      chk("ram_addr", bus.ram_addr, bus.req_addr[g*AW +: AW]);
      if (bus.req_we[g]) chk("ram_wdata", bus.ram_wdata, bus.req_wdata[g*DW +: DW]);
    end else begin
      chk("ram_we_idle", obs_we, 0);
      if (m_prev_rd) chk("reread_addr", bus.ram_addr, m_last_addr);
    end
    exp_rsp = '0;
    exp_dat = m_last_rdata;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_rsp[rsp_q[0].idx] = 1'b1;
      exp_dat = rsp_q[0].data;
      m_last_rdata = exp_dat;
      void'(rsp_q.pop_front());
    end
    chk("rsp_valid", obs_rsp_vld, exp_rsp);
    chk("rsp_rdata", obs_rsp_dat, exp_dat);
    chk("rsp_rdata_known", $isunknown(obs_rsp_dat), 0);
    @(posedge clk);
    m_prev_rd = 1'b0;
    if (g >= 0) begin
      logic [AW-1:0] a;
      a = bus.req_addr[g*AW +: AW];
      m_last_addr = a;
      if (bus.req_we[g]) ref_mem[a] = bus.req_wdata[g*DW +: DW];
      else begin
        rsp_q.push_back('{due: cyc + 2, idx: g, data: ref_mem[a]});
        m_prev_rd = 1'b1;
      end
      if (!m_locked) begin
        if (bus.req_last[g]) m_ptr = (g + 1) % N;
        else begin m_locked = 1'b1; m_lock = g; end
      end else if (bus.req_last[g]) begin
        m_locked = 1'b0;
        m_ptr = (m_lock + 1) % N;
      end
    end
    acc_g = g;
    cyc++;
    #1;
  endtask

  // Asserts reset asynchronously (mid-cycle), checks cleared outputs, releases cleanly.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_ram_cs", bus.ram_cs, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    clear_reqs();
    m_ptr = 0; m_lock = 0; m_locked = 1'b0; m_prev_rd = 1'b0;
    m_last_addr = '0; m_last_rdata = '0;
    rsp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pre_en = 1'b0; pre_addr = '0; pre_dat = '0;
    clear_reqs();
    for (int a = 0; a < 16; a++) preload(AW'(a), $urandom);
    preload(4'd3, 32'hA5A5_0001);
    apply_reset();

    // Lone read, then idle: capture cycle keeps cs high, response in T+2
    set_req(0, 1, 0, 1, 4'd3, '0);
    tick();
    chk("single_grant", obs_rdy, 2'b01);
    clear_reqs();
    tick();
    chk("capture_cs", obs_cs, 1);
    chk("capture_we", obs_we, 0);
    tick();
    chk("single_rsp_valid", obs_rsp_vld, 2'b01);
    chk("single_rsp_rdata", obs_rsp_dat, 32'hA5A5_0001);
    chk("idle_cs", obs_cs, 0);

    // Contention from reset: alternating grants
    apply_reset();
    set_req(0, 1, 0, 1, 4'd1, '0);
    set_req(1, 1, 0, 1, 4'd2, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("contention_grant", obs_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    clear_reqs();
    repeat (3) tick();

    // Burst lock: req1 3-beat burst with a bubble, req0 waiting throughout
    set_req(0, 1, 1, 1, 4'd7, 32'h1111_0007);
    tick();
    chk("burst_pre", obs_rdy, 2'b01);
    set_req(0, 1, 0, 1, 4'd8, '0);
    set_req(1, 1, 1, 0, 4'd9, 32'h2222_0001);
    tick();
    chk("burst_beat1", obs_rdy, 2'b10);
    set_req(1, 1, 1, 0, 4'd10, 32'h2222_0002);
    tick();
    chk("burst_beat2", obs_rdy, 2'b10);
    set_req(1, 0, 0, 0, '0, '0);
    tick();
    chk("burst_bubble", obs_rdy, 2'b00);
    set_req(1, 1, 1, 1, 4'd11, 32'h2222_0003);
    tick();
    chk("burst_beat3", obs_rdy, 2'b10);
    set_req(1, 0, 0, 0, '0, '0);
    tick();
    chk("burst_release", obs_rdy, 2'b01);
    clear_reqs();
    repeat (3) tick();

    // Read-after-write to the same address on consecutive cycles
    set_req(0, 1, 1, 1, 4'd5, 32'hDEAD_BEEF);
    tick();
    chk("raw_write_grant", obs_rdy, 2'b01);
    clear_reqs();
    set_req(1, 1, 0, 1, 4'd5, '0);
    tick();
    chk("raw_read_grant", obs_rdy, 2'b10);
    clear_reqs();
    tick();
    tick();
    chk("raw_rsp_valid", obs_rsp_vld, 2'b10);
    chk("raw_rsp_rdata", obs_rsp_dat, 32'hDEAD_BEEF);

    // Reset in the cycle after a read is accepted: the read is dropped
    set_req(0, 1, 0, 1, 4'd6, '0);
    tick();
    apply_reset();
    repeat (4) begin
      tick();
      chk("post_reset_no_rsp", obs_rsp_vld, 2'b00);
    end

    // Randomized traffic: mixed reads/writes, bursts of 1..3 beats, bubbles
    for (int i = 0; i < N; i++) begin held[i] = 1'b0; left[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!held[i]) begin
          if (left[i] == 0 && $urandom_range(0, 1) == 1) left[i] = $urandom_range(1, 3);
          if (left[i] > 0 && $urandom_range(0, 3) != 0) begin
            held[i] = 1'b1;
            set_req(i, 1, $urandom_range(0, 1) == 1, left[i] == 1, AW'($urandom_range(0, 15)), $urandom);
          end else begin
            set_req(i, 0, 0, 0, '0, '0);
          end
        end
      end
      tick();
      if (acc_g >= 0) begin
        held[acc_g] = 1'b0;
        left[acc_g] = left[acc_g] - 1;
      end
    end
    clear_reqs();
    repeat (4) tick();
    chk("drain_empty", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
